// File: rtl/traffic_light_monitor.sv
// Passive lamp checker for the traffic light controller: decodes the six lamps
// into phases and flags encoding, conflict, order and dwell-time violations.
module traffic_light_monitor #(
    parameter int GREEN_TIME  = 5,
    parameter int YELLOW_TIME = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ns_red,
    input  logic        ns_yellow,
    input  logic        ns_green,
    input  logic        ew_red,
    input  logic        ew_yellow,
    input  logic        ew_green,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        err_onehot,
    output logic        err_conflict,
    output logic        err_sequence,
    output logic        err_timing,
    output logic        err_sticky,
    output logic [15:0] cycle_cnt
);

    localparam int MAX_TIME  = (GREEN_TIME > YELLOW_TIME) ? GREEN_TIME : YELLOW_TIME;
    localparam int DWELL_SAT = MAX_TIME + 1;
    localparam int DW        = $clog2(DWELL_SAT + 1);

    typedef enum logic [2:0] {
        PH_NONE = 3'd0,
        PH_NS_G = 3'd1,
        PH_NS_Y = 3'd2,
        PH_EW_G = 3'd3,
        PH_EW_Y = 3'd4
    } phase_t;

    phase_t          phase_q;
    logic [DW-1:0]   dwell;
    phase_t          sample_ph;
    logic [DW-1:0]   dwell_inc;
    logic            onehot_bad;
    logic            conflict;
    logic            valid;
    logic            same;
    logic            legal;
    logic            overrun;
    logic            underrun;
    logic            seq_bad;
    logic            cnt_inc;

    function automatic logic [DW-1:0] limit_of(input phase_t p);
        case (p)
            PH_NS_G, PH_EW_G: limit_of = DW'(GREEN_TIME);
            PH_NS_Y, PH_EW_Y: limit_of = DW'(YELLOW_TIME);
            default:          limit_of = '0;
        endcase
    endfunction

    function automatic phase_t succ_of(input phase_t p);
        case (p)
            PH_NS_G: succ_of = PH_NS_Y;
            PH_NS_Y: succ_of = PH_EW_G;
            PH_EW_G: succ_of = PH_EW_Y;
            PH_EW_Y: succ_of = PH_NS_G;
            default: succ_of = PH_NONE;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        onehot_bad = ({1'b0, ns_red} + {1'b0, ns_yellow} + {1'b0, ns_green} != 2'd1) ||
                     ({1'b0, ew_red} + {1'b0, ew_yellow} + {1'b0, ew_green} != 2'd1);
        conflict   = !ns_red && !ew_red;

        // With clean one-hot lamps and at least one red, at most one phase can match.
        sample_ph = PH_NONE;
        if (!onehot_bad && !conflict) begin
            if (ns_green)       sample_ph = PH_NS_G;
            else if (ns_yellow) sample_ph = PH_NS_Y;
            else if (ew_green)  sample_ph = PH_EW_G;
            else if (ew_yellow) sample_ph = PH_EW_Y;
        end

        valid     = (sample_ph != PH_NONE);
        dwell_inc = (dwell == DW'(DWELL_SAT)) ? dwell : dwell + DW'(1);
        same      = valid && (sample_ph == phase_q);
        legal     = valid && (phase_q != PH_NONE) && (sample_ph == succ_of(phase_q));
        // Comparing the old dwell to the limit keeps a saturated dwell from re-pulsing.
        overrun   = same && (dwell == limit_of(phase_q));
        underrun  = legal && locked && (dwell < limit_of(phase_q));
        seq_bad   = valid && (phase_q != PH_NONE) && !same && !legal;
        cnt_inc   = legal && (phase_q == PH_EW_Y) && !underrun;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q      <= PH_NONE;
            dwell        <= '0;
            locked       <= 1'b0;
            err_onehot   <= 1'b0;
            err_conflict <= 1'b0;
            err_sequence <= 1'b0;
            err_timing   <= 1'b0;
            err_sticky   <= 1'b0;
            cycle_cnt    <= '0;
        end else begin
            err_onehot   <= onehot_bad;
            err_conflict <= conflict;
            err_sequence <= seq_bad;
            err_timing   <= overrun || underrun;
            err_sticky   <= err_sticky || onehot_bad || conflict || seq_bad || overrun || underrun;

            if (!valid) begin
                phase_q <= PH_NONE;
                dwell   <= '0;
                locked  <= 1'b0;
            end else if (phase_q == PH_NONE) begin
                phase_q <= sample_ph;
                dwell   <= DW'(1);
                locked  <= 1'b0;
            end else if (same) begin
                dwell   <= dwell_inc;
            end else begin
                phase_q <= sample_ph;
                dwell   <= DW'(1);
                locked  <= legal;
                if (cnt_inc) cycle_cnt <= cycle_cnt + 16'd1;
            end
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor against an
// integer reference model of the phase/dwell rules.
module tb_traffic_light_monitor;

    localparam int G_T = 5;
    localparam int Y_T = 2;
    localparam int SAT = ((G_T > Y_T) ? G_T : Y_T) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ns_red, ns_yellow, ns_green;
    logic        ew_red, ew_yellow, ew_green;
    logic [2:0]  phase;
    logic        locked;
    logic        err_onehot, err_conflict, err_sequence, err_timing, err_sticky;
    logic [15:0] cycle_cnt;

    traffic_light_monitor #(.GREEN_TIME(G_T), .YELLOW_TIME(Y_T)) dut (
        .clk          (clk),
        .rst          (rst),
        .ns_red       (ns_red),
        .ns_yellow    (ns_yellow),
        .ns_green     (ns_green),
        .ew_red       (ew_red),
        .ew_yellow    (ew_yellow),
        .ew_green     (ew_green),
        .phase        (phase),
        .locked       (locked),
        .err_onehot   (err_onehot),
        .err_conflict (err_conflict),
        .err_sequence (err_sequence),
        .err_timing   (err_timing),
        .err_sticky   (err_sticky),
        .cycle_cnt    (cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int lim [5] = '{0, G_T, Y_T, G_T, Y_T};
    int m_phase, m_dwell, m_locked, m_cnt, m_sticky;
    int m_on, m_cf, m_sq, m_tm;

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] lamps_of(input int p);
        // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
        case (p)
            1:       lamps_of = 6'b001_100;
            2:       lamps_of = 6'b010_100;
            3:       lamps_of = 6'b100_001;
            4:       lamps_of = 6'b100_010;
            default: lamps_of = 6'b100_100;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_dwell = 0; m_locked = 0; m_cnt = 0; m_sticky = 0;
        m_on = 0; m_cf = 0; m_sq = 0; m_tm = 0;
    endtask

    task automatic model_update(input logic [5:0] v);
        int nr, ny, ng, er, ey, eg, nmatch, dec, nd;
        bit ok;
        {nr, ny, ng, er, ey, eg} = {int'(v[5]), int'(v[4]), int'(v[3]), int'(v[2]), int'(v[1]), int'(v[0])};
        m_on = ((nr + ny + ng) != 1) || ((er + ey + eg) != 1);
        m_cf = (nr == 0) && (er == 0);
        m_sq = 0;
        m_tm = 0;
        nmatch = 0;
        dec = 0;
        if (ng && er) begin nmatch++; dec = 1; end
        if (ny && er) begin nmatch++; dec = 2; end
        if (eg && nr) begin nmatch++; dec = 3; end
        if (ey && nr) begin nmatch++; dec = 4; end
        ok = !m_on && !m_cf && (nmatch == 1);
        if (!ok) begin
            m_phase = 0; m_dwell = 0; m_locked = 0;
        end else if (m_phase == 0) begin
            m_phase = dec; m_dwell = 1; m_locked = 0;
        end else if (dec == m_phase) begin
            nd = (m_dwell + 1 > SAT) ? SAT : m_dwell + 1;
            if (nd == lim[m_phase] + 1 && nd != m_dwell) m_tm = 1;
            m_dwell = nd;
        end else if (dec == (m_phase % 4) + 1) begin
            if (m_locked && m_dwell < lim[m_phase]) m_tm = 1;
            if (m_phase == 4 && !m_tm) m_cnt = (m_cnt + 1) % 65536;
            m_phase = dec; m_dwell = 1; m_locked = 1;
        end else begin
            m_sq = 1;
            m_phase = dec; m_dwell = 1; m_locked = 0;
        end
        if (m_on || m_cf || m_sq || m_tm) m_sticky = 1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".phase"},    int'(phase),        m_phase);
        check({tag, ".locked"},   int'(locked),       m_locked);
        check({tag, ".onehot"},   int'(err_onehot),   m_on);
        check({tag, ".conflict"}, int'(err_conflict), m_cf);
        check({tag, ".sequence"}, int'(err_sequence), m_sq);
        check({tag, ".timing"},   int'(err_timing),   m_tm);
        check({tag, ".sticky"},   int'(err_sticky),   m_sticky);
        check({tag, ".cnt"},      int'(cycle_cnt),    m_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".phase"},  int'(phase), 0);
        check({tag, ".locked"}, int'(locked), 0);
        check({tag, ".errs"},   int'({err_onehot, err_conflict, err_sequence, err_timing}), 0);
        check({tag, ".sticky"}, int'(err_sticky), 0);
        check({tag, ".cnt"},    int'(cycle_cnt), 0);
    endtask

    task automatic step(input string tag, input logic [5:0] v);
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = v;
        @(posedge clk);
        model_update(v);
        #1;
        check_all(tag);
    endtask

    task automatic run_phase(input string tag, input int p, input int n);
        repeat (n) step(tag, lamps_of(p));
    endtask

    // Reset asserted between edges; outputs must clear before any edge arrives.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        model_reset();
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = 6'b001_001;
        @(posedge clk);
        #2;
        check_reset_values({tag, ".hold"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p, q;
        rst = 1'b1;
        {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green} = 6'b000_000;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        // Well-behaved controller starting in NS_G
        for (int i = 0; i < 60; i++) begin
            p = ((i % 14) < 5) ? 1 : ((i % 14) < 7) ? 2 : ((i % 14) < 12) ? 3 : 4;
            step("nominal", lamps_of(p));
        end
        check("nominal.cnt4", int'(cycle_cnt), 4);
        check("nominal.clean", int'(err_sticky), 0);
        check("nominal.locked", int'(locked), 1);

        // Overrun: NS_G held for 7 samples
        async_reset("rst_mid1");
        run_phase("overrun", 1, 5);
        check("overrun.before", int'(err_timing), 0);
        run_phase("overrun", 1, 1);
        check("overrun.sixth", int'(err_timing), 1);
        run_phase("overrun", 1, 1);
        check("overrun.once", int'(err_timing), 0);
        run_phase("overrun", 2, 2);
        run_phase("overrun", 3, 5);
        run_phase("overrun", 4, 2);
        run_phase("overrun", 1, 5);
        check("overrun.sticky", int'(err_sticky), 1);

        // Underrun: locked EW_G left after 3 samples, then a short EW_Y
        run_phase("underrun", 2, 2);
        run_phase("underrun", 3, 3);
        run_phase("underrun", 4, 1);
        check("underrun.pulse", int'(err_timing), 1);
        check("underrun.locked", int'(locked), 1);
        run_phase("underrun", 1, 1);
        check("underrun.nocnt", int'(cycle_cnt), 1);
        run_phase("underrun", 1, 4);
        run_phase("underrun", 2, 2);
        run_phase("underrun", 3, 5);
        run_phase("underrun", 4, 2);
        run_phase("underrun", 1, 1);
        check("underrun.cnt", int'(cycle_cnt), 2);

        // Skip NS_G -> EW_G, short unlocked EW_G not flagged
        run_phase("skip", 1, 4);
        run_phase("skip", 3, 1);
        check("skip.seq", int'(err_sequence), 1);
        check("skip.phase", int'(phase), 3);
        check("skip.locked", int'(locked), 0);
        run_phase("skip", 3, 1);
        run_phase("skip", 4, 1);
        check("skip.no_underrun", int'(err_timing), 0);

        // Both greens, both reds off; then NS red+green together
        step("conflict", 6'b001_001);
        check("conflict.pulse", int'(err_conflict), 1);
        check("conflict.onehot", int'(err_onehot), 0);
        check("conflict.phase", int'(phase), 0);
        step("onehot", 6'b101_100);
        check("onehot.pulse", int'(err_onehot), 1);
        run_phase("recover", 1, 3);

        // Randomised traffic with occasional skips and garbage samples
        async_reset("rst_mid2");
        p = 1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 99) < 8) begin
                step("rand_garbage", 6'($urandom));
            end
            if ($urandom_range(0, 99) < 80) q = (p % 4) + 1;
            else                            q = $urandom_range(1, 4);
            run_phase("rand", q, (q % 2 == 1) ? $urandom_range(3, 7) : $urandom_range(1, 4));
            p = q;
        end

        async_reset("rst_end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker that sits on the six lamp outputs of the traffic light controller and decodes them back into controller phases. It verifies the lamp encoding, the NS/EW mutual exclusion, the phase order and the per-phase dwell times against the same timing parameters the controller uses. It flags every violation as a one-cycle pulse and keeps a sticky error and a count of completed cycles. It has no effect on the controller and is used in benches and as an on-chip safety monitor.

## Interface
- GREEN_TIME, 5: required dwell, in clock cycles, of each green phase.
- YELLOW_TIME, 2: required dwell, in clock cycles, of each yellow phase.
- clk  in  1  single clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ns_red, ns_yellow, ns_green  in  1 each  NS lamps under observation.
- ew_red, ew_yellow, ew_green  in  1 each  EW lamps under observation.
- phase  out  3  decoded phase: 0 NONE, 1 NS_G, 2 NS_Y, 3 EW_G, 4 EW_Y.
- locked  out  1  current phase was entered by a legal transition.
- err_onehot  out  1  pulse: a direction does not have exactly one lamp lit.
- err_conflict  out  1  pulse: ns_red=0 and ew_red=0 together.
- err_sequence  out  1  pulse: illegal phase transition.
- err_timing  out  1  pulse: dwell overrun or underrun.
- err_sticky  out  1  set by any error pulse; cleared only by rst.
- cycle_cnt  out  16  count of clean EW_Y->NS_G transitions.

## Operation
- Decode of each sample:
  - NS_G = ns_green and ew_red.
  - NS_Y = ns_yellow and ew_red.
  - EW_G = ew_green and ns_red.
  - EW_Y = ew_yellow and ns_red.
  - Anything else is INVALID.
- A per-direction check sets err_onehot. The conflict check sets err_conflict. Both can pulse in the same cycle.
- Legal order: NS_G->NS_Y->EW_G->EW_Y->NS_G. Limit is GREEN_TIME for the G phases and YELLOW_TIME for the Y phases.
- Internal state: phase, locked, and dwell (the number of consecutive samples in the current phase).
  - dwell saturates at max(GREEN_TIME, YELLOW_TIME)+1.
  - dwell is never allowed to wrap.
- INVALID sample:
  - phase<=NONE, dwell<=0, locked<=0.
  - The matching onehot/conflict pulse fires.
- Valid sample while phase=NONE: adopt the decoded phase, dwell<=1, locked<=0. No sequence or timing check.
- Valid sample equal to the current phase: dwell increments (saturating).
  - If the incremented dwell equals limit+1, err_timing fires (overrun).
  - This fires only once per overrun; further samples do not re-pulse.
- Valid sample with a legal successor phase:
  - Adopt the new phase, dwell<=1, locked<=1.
  - If the old phase was locked and old dwell < its limit, err_timing fires (underrun).
  - An overrun already flagged is not re-flagged here.
- Valid sample with an illegal successor phase (skip or reverse):
  - err_sequence fires.
  - Adopt the new phase, dwell<=1, locked<=0.
  - No timing check on this edge.
- cycle_cnt increments on a legal EW_Y->NS_G transition only when that edge raises no err_timing. It wraps 16'hFFFF->0.
- err_sticky <= err_sticky OR any error condition detected on this edge.

## Timing
- All outputs are registered.
- Latency: a sample taken on rising edge k is reflected in phase/locked/cnt/flags from edge k onward, i.e. valid in the cycle after edge k. Error pulses are high for exactly that one cycle.
- Reset values:
  - phase=0 (NONE), locked=0, all err_*=0, err_sticky=0, cycle_cnt=0.
  - Internal dwell=0.
- rst asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Lamp values during rst are ignored. The first sample taken on the first rising edge after rst falls is treated as post-reset (phase NONE).
- Nominal period for the defaults is 14 cycles. With the controller starting in NS_G at reset release, the first cycle_cnt increment is visible 14 cycles after the first NS_G sample.

## Test plan
- Reset, then a correct controller model with GREEN=5, YELLOW=2 for 60 cycles:
  - Phase sequence 1,1,1,1,1,2,2,3,... as above.
  - locked=1 from the first NS_Y onward.
  - No err_* pulses.
  - cycle_cnt=4.
- Hold NS_G for 7 samples:
  - err_timing pulses once, on the 6th sample.
  - err_sticky=1 thereafter.
  - No pulse on the later NS_Y transition.
- Locked EW_G left after 3 samples into EW_Y:
  - err_timing pulse.
  - locked stays 1.
  - cycle_cnt is not incremented at the next EW_Y->NS_G transition if that transition is short; it is incremented if that transition is clean.
- Drive NS_G directly to EW_G:
  - err_sequence pulse, phase=3, locked=0.
  - A short EW_G dwell is not flagged as an underrun.
- Drive ns_green=1, ew_green=1, both reds 0 for one cycle:
  - err_conflict pulse, phase=0.
  - err_onehot stays 0.
  - Then drive ns_red=ns_green=1: err_onehot pulse.
- Assert rst asynchronously between edges mid-cycle:
  - All outputs return to reset values before the next edge, including err_sticky=0 and cycle_cnt=0.
